// File: rtl/trig_gate_timer.sv
// rtl/trig_gate_timer.sv - trigger-to-gate delay/width/holdoff timer; optional retrigger via TRIG_GATE_TIMER_RETRIG_EN
module trig_gate_timer #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ext_trig,
  input  logic             sw_trig,
  input  logic             enable,
  input  logic             auto_rearm,
  input  logic [CNT_W-1:0] delay_cycles,
  input  logic [CNT_W-1:0] width_cycles,
  input  logic [CNT_W-1:0] holdoff_cycles,
  output logic             gate_en,
  output logic             armed,
  output logic             busy,
  output logic [CNT_W-1:0] trig_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_OPEN,
    S_HOLDOFF,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ext_q;
  logic             sw_q;
  logic [CNT_W-1:0] d_lat;
  logic [CNT_W-1:0] w_lat;
  logic [CNT_W-1:0] h_lat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             trig_evt;
  logic             accept;
  logic             retrig;

  // Either trigger source rising counts as a single event.
  assign trig_evt = (ext_trig & ~ext_q) | (sw_trig & ~sw_q);

  // Next state and phase counter; cnt is the 1-based cycle index within the
  // current timed phase, and zero-length phases are skipped when chaining.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    retrig    = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_ARMED;
        S_ARMED: begin
          if (trig_evt) begin
            accept  = 1'b1;
            cnt_nxt = CNT_ONE;
            if (delay_cycles != '0)        state_nxt = S_DELAY;
            else if (width_cycles != '0)   state_nxt = S_OPEN;
            else if (holdoff_cycles != '0) state_nxt = S_HOLDOFF;
            else                           state_nxt = auto_rearm ? S_ARMED : S_DONE;
          end
        end
        S_DELAY: begin
          if (cnt != d_lat) begin
            cnt_nxt = cnt + CNT_ONE;
          end else begin
            cnt_nxt = CNT_ONE;
            if (w_lat != '0)      state_nxt = S_OPEN;
            else if (h_lat != '0) state_nxt = S_HOLDOFF;
            else                  state_nxt = auto_rearm ? S_ARMED : S_DONE;
          end
        end
        S_OPEN: begin
`ifdef TRIG_GATE_TIMER_RETRIG_EN
          retrig = trig_evt;
`endif
          if (retrig) begin
            cnt_nxt = CNT_ONE;
          end else if (cnt != w_lat) begin
            cnt_nxt = cnt + CNT_ONE;
          end else begin
            cnt_nxt = CNT_ONE;
            if (h_lat != '0) state_nxt = S_HOLDOFF;
            else             state_nxt = auto_rearm ? S_ARMED : S_DONE;
          end
        end
        S_HOLDOFF: begin
          if (cnt != h_lat) cnt_nxt = cnt + CNT_ONE;
          else              state_nxt = auto_rearm ? S_ARMED : S_DONE;
        end
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, trigger history, latched timing, trigger count and status flags;
  // gate_en and busy show the phase held during the previous cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ext_q      <= 1'b0;
      sw_q       <= 1'b0;
      d_lat      <= '0;
      w_lat      <= '0;
      h_lat      <= '0;
      trig_count <= '0;
      gate_en    <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ext_q <= ext_trig;
      sw_q  <= sw_trig;
      if (accept) begin
        d_lat <= delay_cycles;
        w_lat <= width_cycles;
        h_lat <= holdoff_cycles;
      end
      if (accept || retrig) trig_count <= trig_count + CNT_ONE;
      armed   <= (state_nxt == S_ARMED);
      gate_en <= enable && (state == S_OPEN);
      busy    <= enable && ((state == S_DELAY) || (state == S_OPEN) || (state == S_HOLDOFF));
    end
  end

endmodule

// File: doc/trig_gate_timer.md
TRIG_GATE_TIMER -- requirements
Module: trig_gate_timer

Interface
REQ-001 Parameter CNT_W, default 16: width of the delay, width and holdoff counters and of trig_count.
REQ-002 Port Clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 Port Reset, input, 1: synchronous, active-high reset.
REQ-004 Port ext_trig, input, 1: external trigger level (ExtTrig), synchronous to Clk.
REQ-005 Port sw_trig, input, 1: software trigger level (a Control register bit).
REQ-006 Port enable, input, 1: level; 1 = block enabled, 0 = abort and idle.
REQ-007 Port auto_rearm, input, 1: 1 = re-arm after holdoff, 0 = single-shot.
REQ-008 Port delay_cycles, input, CNT_W: trigger-to-gate delay D.
REQ-009 Port width_cycles, input, CNT_W: gate-open length W.
REQ-010 Port holdoff_cycles, input, CNT_W: dead time H after the gate closes.
REQ-011 Port gate_en, output, 1: registered gate; drives the select of the downstream output gate stage.
REQ-012 Port armed, output, 1: registered; 1 only in state ARMED.
REQ-013 Port busy, output, 1: registered; 1 in DELAY, OPEN or HOLDOFF.
REQ-014 Port trig_count, output, CNT_W: count of accepted triggers.

Function
REQ-015 States: IDLE, ARMED, DELAY, OPEN, HOLDOFF, DONE.
REQ-016 Trigger event: edge detected on a clock edge where (ext_trig & ~ext_q) | (sw_trig & ~sw_q), with ext_q and sw_q the values registered on the previous edge; a simultaneous edge on both inputs counts as one event.
REQ-017 Transition IDLE->ARMED on any edge where enable=1.
REQ-018 Accepted trigger: a trigger event in ARMED; D, W and H are latched on that edge (t0), and later input changes have no effect until the next accepted trigger.
REQ-019 Gate timing: gate_en=1 for exactly W cycles, from edge t0+D+1 through edge t0+D+W; D=0 gives gate_en=1 from t0+1.
REQ-020 W=0: gate_en never asserts; after D cycles the FSM enters HOLDOFF directly.
REQ-021 HOLDOFF lasts H cycles after the gate closes; H=0 exits HOLDOFF immediately.
REQ-022 HOLDOFF exit: to ARMED if auto_rearm=1, otherwise to DONE; auto_rearm is sampled on the exit edge.
REQ-023 The earliest re-accepted trigger is on edge t0+D+W+H+1; trigger events in DELAY, HOLDOFF, IDLE and DONE are ignored and not counted.
REQ-024 DONE holds gate_en=0 and armed=0 until enable=0.
REQ-025 enable=0 on any edge forces IDLE, and gate_en, armed and busy read 0 after that edge (abort mid-gate permitted).
REQ-026 trig_count increments by 1 per accepted trigger and wraps from 2^CNT_W-1 to 0; it is not cleared by enable.
REQ-027 A trigger event coincident with the edge entering ARMED is not accepted.

Reset
REQ-028 On Reset=1 at a clock edge: state IDLE; gate_en, armed and busy 0; trig_count 0; ext_q and sw_q 0; latched D, W and H 0.
REQ-029 Reset overrides enable and triggers on the same edge; a trigger input held high across reset release generates no event.

Configuration
REQ-030 Macro TRIG_GATE_TIMER_RETRIG_EN: when defined, a trigger event in OPEN is accepted, increments trig_count and reloads the width counter, so gate_en stays 1 for W further cycles after that edge; D and H are not re-latched.
REQ-031 When TRIG_GATE_TIMER_RETRIG_EN is not defined, trigger events in OPEN are ignored and not counted.

Verification
REQ-032 Scenario: enable=1, auto_rearm=0, D=3, W=5, H=2, ext_trig pulse detected at t0 -> gate_en high on edges t0+4..t0+8, busy through t0+10, then DONE; trig_count=1.
REQ-033 Scenario: D=0, W=1, auto_rearm=1, sw_trig edges every 4 cycles, H=0 -> 1-cycle gate at t0+1; a trigger at t0+2 is accepted and a trigger at t0+1 is ignored.
REQ-034 Scenario: W=0, D=2, H=3 -> gate_en never asserts, busy for 5 cycles, trig_count increments.
REQ-035 Scenario: enable dropped at t0+D+2 during OPEN with W=10 -> gate_en=0 from the next edge, state IDLE; re-enable returns to ARMED.
REQ-036 Scenario: with TRIG_GATE_TIMER_RETRIG_EN, W=4, a second trigger at gate cycle 3 -> gate_en continuous for 7 cycles, trig_count=2; without the macro -> 4 cycles, trig_count=1.
REQ-037 Scenario: CNT_W=4, 16 accepted triggers -> trig_count wraps to 0; Reset held with ext_trig=1 and then released -> no trigger accepted.
